status_branch_unit: RTL and testbench

- Consumer end of the ALU status-flag interface.
- Owns the architectural N/V/Z status register, loaded by the ALU's flag-update strobe.
- Resolves flag-conditioned branches (brz/brn/brv/blez, each with an optional link variant such as blezal) through a valid/ready request/response handshake.
- For link variants, emits a one-cycle register-file write of the return address to the link register.

---
 rtl/br_pkg.sv | 27 ++
 rtl/br_cond_eval.sv | 24 ++
 rtl/status_branch_unit.sv | 118 +++++++++++
 tb/tb_status_branch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the status/branch unit.
// Also used by the decode-stage predictor.
package br_pkg;

    typedef enum logic [1:0] {
        COND_Z   = 2'b00,
        COND_N   = 2'b01,
        COND_V   = 2'b10,
        COND_LEZ = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_LINK,
        S_RESP
    } state_e;

    typedef struct packed {
        logic       link;
        logic [1:0] cond;
    } br_op_t;

    localparam int LINK_REG_DEF = 31;
    localparam int PC_INC       = 4;

endpackage

// File: rtl/br_cond_eval.sv
// Flag-condition evaluator, purely combinational.
// Shared with the decode-stage predictor.
module br_cond_eval
    import br_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       n,
    input  logic       v,
    input  logic       z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (cond == COND_Z):   taken = z;
            (cond == COND_N):   taken = n;
            (cond == COND_V):   taken = v;
            (cond == COND_LEZ): taken = z | n;
            default:            taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_branch_unit.sv
// N/V/Z status register and flag-conditioned branch resolver
// with optional link-register write.
module status_branch_unit
    import br_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic            flag_n,
    input  logic            flag_v,
    input  logic            flag_z,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_target,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [PC_W-1:0] res_next_pc,
    output logic            link_we,
    output logic [4:0]      link_addr,
    output logic [PC_W-1:0] link_data,
    output logic            stat_n,
    output logic            stat_v,
    output logic            stat_z
);

    state_e          state;
    br_op_t          op_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] tgt_q;
    logic [PC_W-1:0] pc_inc;
    logic            taken;

    assign link_addr = 5'(LINK_REG);
    assign pc_inc    = pc_q + PC_W'(PC_INC);

    br_cond_eval u_cond (
        .cond  (op_q.cond),
        .n     (stat_n),
        .v     (stat_v),
        .z     (stat_z),
        .taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_n <= 1'b0;
            stat_v <= 1'b0;
            stat_z <= 1'b0;
        end else if (flag_we) begin
            stat_n <= flag_n;
            stat_v <= flag_v;
            stat_z <= flag_z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            br_ready    <= 1'b0;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_next_pc <= '0;
            link_we     <= 1'b0;
            link_data   <= '0;
            op_q        <= '0;
            pc_q        <= '0;
            tgt_q       <= '0;
        end else begin
            link_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    br_ready <= 1'b1;
                    if (br_valid && br_ready) begin
                        op_q     <= br_op;
                        pc_q     <= br_pc;
                        tgt_q    <= br_target;
                        br_ready <= 1'b0;
                        state    <= S_EVAL;
                    end
                end
                // A flag write in flight means stat_* is stale; wait for it.
                S_EVAL: begin
                    if (!flag_we) begin
                        res_taken   <= taken;
                        res_next_pc <= taken ? tgt_q : pc_inc;
                        link_data   <= pc_inc;
                        if (op_q.link) begin
                            link_we <= 1'b1;
                            state   <= S_LINK;
                        end else begin
                            res_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_LINK: begin
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        br_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed self-checking bench for status_branch_unit.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_status_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we, flag_n, flag_v, flag_z;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_op;
    logic [31:0] br_pc, br_target;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [31:0] res_next_pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        stat_n, stat_v, stat_z;

    int errors = 0;
    int checks = 0;
    int link_cnt = 0;

    status_branch_unit #(.PC_W(32), .LINK_REG(31)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_we     (flag_we),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .flag_z      (flag_z),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_op       (br_op),
        .br_pc       (br_pc),
        .br_target   (br_target),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_taken   (res_taken),
        .res_next_pc (res_next_pc),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .link_data   (link_data),
        .stat_n      (stat_n),
        .stat_v      (stat_v),
        .stat_z      (stat_z)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (link_we === 1'b1) link_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flag_we = 0; flag_n = 0; flag_v = 0; flag_z = 0;
        br_valid = 0; br_op = 3'b000; br_pc = '0; br_target = '0;
        res_ready = 1'b1;
        #12;
        check("rst_br_ready", 32'(br_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_link_we", 32'(link_we), 0);
        check("rst_stat", {29'd0, stat_n, stat_v, stat_z}, 0);
        check("rst_next_pc", res_next_pc, 0);
        check("link_addr", 32'(link_addr), 31);
        step();
        rst_n = 1'b1;
        step();
        check("idle_br_ready", 32'(br_ready), 1);

        // 1: flags then plain brz, taken
        flag_we = 1; flag_z = 1; flag_n = 0; flag_v = 0;
        step();
        flag_we = 0;
        check("t1_stat", {29'd0, stat_n, stat_v, stat_z}, 32'b001);
        br_valid = 1; br_op = 3'b000; br_pc = 32'h100; br_target = 32'h200;
        step();
        br_valid = 0;
        check("t1_eval_ready", 32'(br_ready), 0);
        check("t1_eval_valid", 32'(res_valid), 0);
        step();
        check("t1_valid", 32'(res_valid), 1);
        check("t1_taken", 32'(res_taken), 1);
        check("t1_next_pc", res_next_pc, 32'h200);
        step();
        check("t1_done_valid", 32'(res_valid), 0);
        check("t1_done_ready", 32'(br_ready), 1);
        check("t1_no_link", 32'(link_cnt), 0);

        // 2: blezal not taken; flags cleared on the accept edge
        flag_we = 1; flag_z = 0; flag_n = 0; flag_v = 0;
        br_valid = 1; br_op = 3'b111; br_pc = 32'h40; br_target = 32'h80;
        step();
        flag_we = 0; br_valid = 0;
        check("t2_stat", {29'd0, stat_n, stat_v, stat_z}, 0);
        step();
        check("t2_link_we", 32'(link_we), 1);
        check("t2_link_addr", 32'(link_addr), 31);
        check("t2_link_data", link_data, 32'h44);
        check("t2_early_valid", 32'(res_valid), 0);
        step();
        check("t2_link_we_off", 32'(link_we), 0);
        check("t2_valid", 32'(res_valid), 1);
        check("t2_taken", 32'(res_taken), 0);
        check("t2_next_pc", res_next_pc, 32'h44);
        step();
        check("t2_link_cnt", 32'(link_cnt), 1);

        // 3: brn with flag hazard for two EVAL cycles
        br_valid = 1; br_op = 3'b001; br_pc = 32'h300; br_target = 32'h400;
        step();
        br_valid = 0;
        flag_we = 1; flag_n = 1;
        step();
        check("t3_hold1", 32'(res_valid), 0);
        check("t3_stat_n", 32'(stat_n), 1);
        step();
        flag_we = 0;
        check("t3_hold2", 32'(res_valid), 0);
        step();
        check("t3_valid", 32'(res_valid), 1);
        check("t3_taken", 32'(res_taken), 1);
        check("t3_next_pc", res_next_pc, 32'h400);
        step();

        // 4: brv not taken under backpressure
        res_ready = 0;
        br_valid = 1; br_op = 3'b010; br_pc = 32'h500; br_target = 32'h600;
        step();
        br_valid = 0;
        step();
        br_valid = 1; br_op = 3'b000; br_pc = 32'h900; br_target = 32'h990;
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", 32'(res_valid), 1);
            check("t4_taken", 32'(res_taken), 0);
            check("t4_next_pc", res_next_pc, 32'h504);
            check("t4_br_ready", 32'(br_ready), 0);
            step();
        end
        br_valid = 0;
        res_ready = 1;
        check("t4_still_valid", 32'(res_valid), 1);
        step();
        check("t4_rel_ready", 32'(br_ready), 1);
        check("t4_rel_valid", 32'(res_valid), 0);
        step();
        check("t4_no_accept", 32'(res_valid), 0);

        // 5: PC wrap, brz with z=0
        br_valid = 1; br_op = 3'b000; br_pc = 32'hFFFF_FFFC;
        br_target = 32'h1234;
        step();
        br_valid = 0;
        step();
        check("t5_valid", 32'(res_valid), 1);
        check("t5_taken", 32'(res_taken), 0);
        check("t5_next_pc", res_next_pc, 32'h0);
        step();

        // 6: reset asserted during LINK
        br_valid = 1; br_op = 3'b100; br_pc = 32'h700; br_target = 32'h800;
        step();
        br_valid = 0;
        step();
        check("t6_in_link", 32'(link_we), 1);
        rst_n = 0;
        #1;
        check("t6_link_we", 32'(link_we), 0);
        check("t6_res_valid", 32'(res_valid), 0);
        check("t6_stat", {29'd0, stat_n, stat_v, stat_z}, 0);
        check("t6_br_ready", 32'(br_ready), 0);
        #1;
        rst_n = 1;
        step();
        check("t6_post_ready", 32'(br_ready), 1);
        step();
        step();
        step();
        check("t6_no_resp", 32'(res_valid), 0);
        check("t6_no_link", 32'(link_we), 0);
        check("t6_link_cnt", 32'(link_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
